alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// alu_mc: ALU with a valid/ready request port and a registered, held result.
// Latency: 1 cycle for single-cycle ops; DATA_WIDTH+1 cycles for MUL (shift-add).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Optional feature macro: ALU_MC_MUL_EN enables MUL (opcode 1100) and the BUSY state.
module alu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero,
  output logic                  CarryOut,
  output logic                  Overflow
);

  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;

`ifdef ALU_MC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam int         CW     = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

  state_t state_q, state_d;

  // Registered result and flags, driven straight to the outputs
  logic [DATA_WIDTH-1:0] res_q;
  logic                  zero_q, cy_q, ov_q;

  // Single-cycle datapath results, computed from the live request inputs
  logic [DATA_WIDTH:0]   add_full;
  logic [DATA_WIDTH-1:0] diff;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_cy, alu_ov;

`ifdef ALU_MC_MUL_EN
  // Shift-add multiplier state: multiplicand shifts left, multiplier right
  logic [DATA_WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_nxt;
  logic [CW-1:0]         cnt_q;
  logic                  is_mul;

  // Partial-product accumulate for the current multiplier bit
  always_comb begin
    is_mul  = (ALUop == OP_MUL);
    acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end
`endif

  // Combinational ALU for all single-cycle opcodes; unknown codes yield 0
  always_comb begin
    add_full = {1'b0, A} + {1'b0, B};
    diff     = A - B;
    shamt    = B[SHAMT_W-1:0];
    alu_res  = '0;
    alu_cy   = 1'b0;
    alu_ov   = 1'b0;
    case (ALUop)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_ADD: begin
        alu_res = add_full[MSB:0];
        alu_cy  = add_full[DATA_WIDTH];
        alu_ov  = (A[MSB] == B[MSB]) && (add_full[MSB] != A[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_cy  = (A < B);
        alu_ov  = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
      end
      // Direct signed compare stays correct even when A-B overflows
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  alu_res = A << shamt;
      OP_SRL:  alu_res = A >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(A) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifdef ALU_MC_MUL_EN
          state_d = is_mul ? S_BUSY : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef ALU_MC_MUL_EN
      S_BUSY:  if (cnt_q == CNT_LAST) state_d = S_DONE;
`endif
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state, result taken from the holding registers
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    Result    = res_q;
    Zero      = zero_q;
    CarryOut  = cy_q;
    Overflow  = ov_q;
  end

  // Datapath: capture on acceptance, iterate the multiplier in BUSY, hold in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      zero_q <= 1'b0;
      cy_q   <= 1'b0;
      ov_q   <= 1'b0;
`ifdef ALU_MC_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      if (state_q == S_IDLE && in_valid) begin
`ifdef ALU_MC_MUL_EN
        if (is_mul) begin
          mcand_q  <= A;
          mplier_q <= B;
          acc_q    <= '0;
          cnt_q    <= '0;
        end else
`endif
        begin
          res_q  <= alu_res;
          zero_q <= (alu_res == '0);
          cy_q   <= alu_cy;
          ov_q   <= alu_ov;
        end
      end
`ifdef ALU_MC_MUL_EN
      if (state_q == S_BUSY) begin
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        acc_q    <= acc_nxt;
        cnt_q    <= cnt_q + CW'(1);
        // Last multiplier bit: publish the final sum directly
        if (cnt_q == CNT_LAST) begin
          res_q  <= acc_nxt;
          zero_q <= (acc_nxt == '0);
          cy_q   <= 1'b0;
          ov_q   <= 1'b0;
        end
      end
`endif
    end
  end

endmodule
